// File: rtl/ahb_slave_bridge.sv
// ---------------------------------------------------------------------------
// ahb_slave_bridge
//
// Purpose:
//   AHB-Lite slave front end that decodes three address windows and turns
//   accepted AHB transfers into simple register-block strobes. Reads take
//   one wait state (rdata is captured into HRDATA). Writes complete with no
//   wait states. Unmapped, oversized or misaligned transfers get the
//   two-cycle AHB ERROR response.
//
// Ports:
//   HCLK        - sole clock
//   HRESET      - synchronous active-high reset
//   HSEL        - slave select
//   HADDR       - address-phase address
//   HTRANS      - transfer type (bit 1 set = NONSEQ/SEQ)
//   HWRITE      - 1 = write
//   HSIZE       - transfer size (0 = byte, 1 = half, 2 = word)
//   HWDATA      - write data, valid in the data phase
//   HREADY      - bus-wide ready
//   HRDATA      - read data returned to the master
//   HREADYOUT   - slave ready
//   HRESP       - 1 = ERROR
//   addr        - latched register address
//   wdata       - write data to the register blocks
//   ren / wen   - read / write strobes
//   addr_valid1..3 - window 1..3 hit, qualified by a strobe
//   rdata       - muxed read data from the rdata arbiter
// ---------------------------------------------------------------------------
module ahb_slave_bridge #(
  parameter logic [31:0] BASE1    = 32'h8000_0000,
  parameter logic [31:0] BASE2    = 32'h8000_1000,
  parameter logic [31:0] BASE3    = 32'h8000_2000,
  parameter int          WIN_BITS = 12
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        ren,
  output logic        wen,
  output logic        addr_valid1,
  output logic        addr_valid2,
  output logic        addr_valid3,
  input  logic [31:0] rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR,
    ERR1,
    ERR2
  } state_t;

  state_t      state_q;
  logic        hreadyOut_q;
  logic        hresp_q;
  logic        ren_q;
  logic        wen_q;
  logic [2:0]  addrValid_q;
  logic [31:0] hrdata_q;
  logic [31:0] addr_q;

  logic        accept_d;
  logic        hit1_d;
  logic        hit2_d;
  logic        hit3_d;
  logic [2:0]  winSel_d;
  logic        misaligned_d;
  logic        error_d;

  // HTRANS[1] alone separates NONSEQ/SEQ from IDLE/BUSY
  logic        unusedHtrans0;
  assign unusedHtrans0 = HTRANS[0];

  // Address-phase decode. The window choice and error verdict are taken
  // here and carried into the data phase through the FSM state and the
  // registered addr_valid vector, so HWRITE/HSIZE need no separate copy.
  assign accept_d = HSEL & HREADY & HTRANS[1];
  assign hit1_d   = (HADDR[31:WIN_BITS] == BASE1[31:WIN_BITS]);
  assign hit2_d   = (HADDR[31:WIN_BITS] == BASE2[31:WIN_BITS]);
  assign hit3_d   = (HADDR[31:WIN_BITS] == BASE3[31:WIN_BITS]);
  // Overlapping windows resolve with window 1 highest priority
  assign winSel_d = hit1_d ? 3'b001 :
                    hit2_d ? 3'b010 :
                    hit3_d ? 3'b100 : 3'b000;

  // Alignment rule depends on the transfer size
  always_comb begin
    misaligned_d = 1'b0;
    case (HSIZE)
      3'd1:    misaligned_d = HADDR[0];
      3'd2:    misaligned_d = |HADDR[1:0];
      default: misaligned_d = 1'b0;
    endcase
  end

  assign error_d = (winSel_d == 3'b000) | (HSIZE > 3'd2) | misaligned_d;

  // Single FSM register block. Every output is registered alongside the
  // next state so the data-phase cycle sees clean, glitch-free strobes.
  // An accepted transfer always wins, which gives back-to-back operation
  // out of IDLE, RD_DONE, WR and ERR2.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      hreadyOut_q <= 1'b1;
      hresp_q     <= 1'b0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      addrValid_q <= 3'b000;
      hrdata_q    <= 32'h0;
      addr_q      <= 32'h0;
    end else begin
      if (state_q == RD_WAIT) begin
        hrdata_q <= rdata;
      end
      if (accept_d) begin
        addr_q <= HADDR;
        if (error_d) begin
          state_q     <= ERR1;
          hreadyOut_q <= 1'b0;
          hresp_q     <= 1'b1;
          ren_q       <= 1'b0;
          wen_q       <= 1'b0;
          addrValid_q <= 3'b000;
        end else if (!HWRITE) begin
          state_q     <= RD_WAIT;
          hreadyOut_q <= 1'b0;
          hresp_q     <= 1'b0;
          ren_q       <= 1'b1;
          wen_q       <= 1'b0;
          addrValid_q <= winSel_d;
        end else begin
          state_q     <= WR;
          hreadyOut_q <= 1'b1;
          hresp_q     <= 1'b0;
          ren_q       <= 1'b0;
          wen_q       <= 1'b1;
          addrValid_q <= winSel_d;
        end
      end else begin
        hreadyOut_q <= 1'b1;
        ren_q       <= 1'b0;
        wen_q       <= 1'b0;
        addrValid_q <= 3'b000;
        case (state_q)
          RD_WAIT: begin
            state_q <= RD_DONE;
            hresp_q <= 1'b0;
          end
          ERR1: begin
            state_q <= ERR2;
            hresp_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            hresp_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign HRDATA      = hrdata_q;
  assign HREADYOUT   = hreadyOut_q;
  assign HRESP       = hresp_q;
  assign addr        = addr_q;
  assign wdata       = HWDATA;
  assign ren         = ren_q;
  assign wen         = wen_q;
  assign addr_valid1 = addrValid_q[0];
  assign addr_valid2 = addrValid_q[1];
  assign addr_valid3 = addrValid_q[2];

endmodule

// File: tb/tb_ahb_slave_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_bridge
//
// Purpose:
//   Self-checking bench for ahb_slave_bridge. A transaction-level model
//   keeps a queue of expected per-cycle slave responses scheduled when a
//   transfer is accepted, plus the expected HRDATA and addr values.
//   Directed transfers come first, then a randomized stream.
// ---------------------------------------------------------------------------
module tb_ahb_slave_bridge;

  typedef struct packed {
    logic       ready;
    logic       resp;
    logic       ren;
    logic       wen;
    logic [1:0] win;
  } resp_t;

  localparam resp_t IDLE_RESP = '{ready: 1'b1, resp: 1'b0, ren: 1'b0, wen: 1'b0, win: 2'd0};

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ren;
  logic        wen;
  logic        addr_valid1;
  logic        addr_valid2;
  logic        addr_valid3;
  logic [31:0] rdata;

  resp_t       sched[$];
  resp_t       cur = IDLE_RESP;
  logic [31:0] expHrdata = 32'h0;
  logic [31:0] expAddr   = 32'h0;
  int          testCount = 0;
  int          failCount = 0;

  ahb_slave_bridge dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .addr        (addr),
    .wdata       (wdata),
    .ren         (ren),
    .wen         (wen),
    .addr_valid1 (addr_valid1),
    .addr_valid2 (addr_valid2),
    .addr_valid3 (addr_valid3),
    .rdata       (rdata)
  );

  always #5 HCLK = ~HCLK;

  // Window number by plain address range; 0 means unmapped
  function automatic logic [1:0] windowOf(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8000_1000) return 2'd1;
    if (a >= 32'h8000_1000 && a < 32'h8000_2000) return 2'd2;
    if (a >= 32'h8000_2000 && a < 32'h8000_3000) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic isError(input logic [31:0] a, input logic [2:0] size);
    if (size > 3'd2) return 1'b1;
    if ((a % (32'd1 << size)) != 32'd0) return 1'b1;
    return windowOf(a) == 2'd0;
  endfunction

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Compare every slave output against the model's view of this cycle
  task automatic sampleOutputs();
    logic [2:0] expValid;
    cur = (sched.size() > 0) ? sched.pop_front() : IDLE_RESP;
    expValid = (cur.win == 2'd0) ? 3'b000 : (3'b001 << (cur.win - 2'd1));
    checkOutput("hreadyout", {31'h0, HREADYOUT}, {31'h0, cur.ready});
    checkOutput("hresp",     {31'h0, HRESP},     {31'h0, cur.resp});
    checkOutput("ren",       {31'h0, ren},       {31'h0, cur.ren});
    checkOutput("wen",       {31'h0, wen},       {31'h0, cur.wen});
    checkOutput("addr_valid", {29'h0, addr_valid3, addr_valid2, addr_valid1}, {29'h0, expValid});
    checkOutput("hrdata",    HRDATA, expHrdata);
    checkOutput("addr",      addr,   expAddr);
    if (cur.wen) checkOutput("wdata", wdata, HWDATA);
  endtask

  // Drive one cycle of bus inputs, update the model, then sample the
  // resulting cycle on the falling edge
  task automatic applyStimulus(input logic rst, input logic sel, input logic [31:0] a,
                               input logic [1:0] trans, input logic wr, input logic [2:0] size,
                               input logic [31:0] wd, input logic rdy, input logic [31:0] rd);
    logic [1:0] w;
    HRESET = rst;
    HSEL   = sel;
    HADDR  = a;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HWDATA = wd;
    HREADY = rdy;
    rdata  = rd;
    if (rst) begin
      sched.delete();
      expHrdata = 32'h0;
      expAddr   = 32'h0;
    end else begin
      if (cur.ren) expHrdata = rd;
      if (sel && rdy && trans[1]) begin
        sched.delete();
        expAddr = a;
        w = windowOf(a);
        if (isError(a, size)) begin
          sched.push_back('{ready: 1'b0, resp: 1'b1, ren: 1'b0, wen: 1'b0, win: 2'd0});
          sched.push_back('{ready: 1'b1, resp: 1'b1, ren: 1'b0, wen: 1'b0, win: 2'd0});
        end else if (!wr) begin
          sched.push_back('{ready: 1'b0, resp: 1'b0, ren: 1'b1, wen: 1'b0, win: w});
        end else begin
          sched.push_back('{ready: 1'b1, resp: 1'b0, ren: 1'b0, wen: 1'b1, win: w});
        end
      end
    end
    @(posedge HCLK);
    @(negedge HCLK);
    sampleOutputs();
  endtask

  task automatic idleCycle(input logic [31:0] wd, input logic [31:0] rd);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 3'd0, wd, cur.ready, rd);
  endtask

  task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] size);
    applyStimulus(1'b0, 1'b1, a, 2'b10, wr, size, $urandom, 1'b1, $urandom);
  endtask

  // Directed scenarios followed by a randomized transfer stream
  initial begin
    logic        rst, sel, wr, rdy;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] a;
    logic [31:0] off;
    int          kind;

    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 2'b10, 1'b0, 3'd2, 32'h0, 1'b1, 32'h5555_5555);
    checkOutput("reset_hrdata", HRDATA, 32'h0);
    checkOutput("reset_ren", {31'h0, ren}, 32'h0);
    idleCycle(32'h0, 32'h0);

    // Read window 2 with one wait state
    xfer(32'h8000_1004, 1'b0, 3'd2);
    checkOutput("rd_ren", {31'h0, ren}, 32'h1);
    checkOutput("rd_valid2", {31'h0, addr_valid2}, 32'h1);
    checkOutput("rd_wait", {31'h0, HREADYOUT}, 32'h0);
    idleCycle(32'h0, 32'hDEAD_BEEF);
    checkOutput("rd_data", HRDATA, 32'hDEAD_BEEF);
    checkOutput("rd_done", {31'h0, HREADYOUT}, 32'h1);

    // Zero-wait write to window 1
    xfer(32'h8000_0010, 1'b1, 3'd2);
    checkOutput("wr_wen", {31'h0, wen}, 32'h1);
    checkOutput("wr_valid1", {31'h0, addr_valid1}, 32'h1);
    idleCycle(32'h1234_5678, 32'h0);
    idleCycle(32'h0, 32'h0);

    // Unmapped read gets a two-cycle error
    xfer(32'h9000_0000, 1'b0, 3'd2);
    checkOutput("err1_resp", {31'h0, HRESP}, 32'h1);
    checkOutput("err1_ready", {31'h0, HREADYOUT}, 32'h0);
    idleCycle(32'h0, 32'h0);
    checkOutput("err2_resp", {31'h0, HRESP}, 32'h1);
    checkOutput("err2_ready", {31'h0, HREADYOUT}, 32'h1);
    idleCycle(32'h0, 32'h0);

    // Back-to-back write then read with no gap
    xfer(32'h8000_2000, 1'b1, 3'd2);
    checkOutput("b2b_valid3", {31'h0, addr_valid3}, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 2'b10, 1'b0, 3'd2, 32'hCAFE_0001, 1'b1, 32'h0);
    checkOutput("b2b_ren", {31'h0, ren}, 32'h1);
    checkOutput("b2b_valid1", {31'h0, addr_valid1}, 32'h1);
    idleCycle(32'h0, 32'h0BAD_F00D);
    idleCycle(32'h0, 32'h0);

    // Reset while a read is waiting
    xfer(32'h8000_1008, 1'b0, 3'd2);
    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 32'h0, 1'b0, 32'h7777_7777);
    checkOutput("rst_mid_hrdata", HRDATA, 32'h0);
    checkOutput("rst_mid_ren", {31'h0, ren}, 32'h0);
    idleCycle(32'h0, 32'h0);

    // Misaligned word transfer
    xfer(32'h8000_0002, 1'b1, 3'd2);
    checkOutput("misalign_resp", {31'h0, HRESP}, 32'h1);
    idleCycle(32'h0, 32'h0);
    idleCycle(32'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      rdy   = cur.ready ? ($urandom_range(0, 7) != 0) : 1'b0;
      sel   = ($urandom_range(0, 3) != 0);
      trans = 2'($urandom_range(0, 3));
      wr    = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      kind  = $urandom_range(0, 5);
      off   = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) off = off & ~((32'd1 << size) - 32'd1);
      case (kind)
        0:       a = 32'h8000_0000 + off;
        1:       a = 32'h8000_1000 + off;
        2:       a = 32'h8000_2000 + off;
        3:       a = 32'h8000_3000 + off;
        4:       a = 32'h7FFF_F000 + off;
        default: a = $urandom;
      endcase
      applyStimulus(rst, sel, a, trans, wr, size, $urandom, rdy, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ahb_slave_bridge.md
AHB_SLAVE_BRIDGE -- requirements
Module: ahb_slave_bridge

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BASE1, 32'h8000_0000, window 1 base
- BASE2, 32'h8000_1000, window 2 base
- BASE3, 32'h8000_2000, window 3 base
- WIN_BITS, 12, log2 of window size in bytes
REQ-002 Ports SHALL be (name, direction, width, meaning):
- HCLK, in, 1, sole clock
- HRESET, in, 1, synchronous active-high reset
- HSEL, in, 1, slave select
- HADDR, in, 32, address-phase address
- HTRANS, in, 2, transfer type
- HWRITE, in, 1, 1 = write
- HSIZE, in, 3, transfer size
- HWDATA, in, 32, write data, data phase
- HREADY, in, 1, bus-wide ready
- HRDATA, out, 32, read data
- HREADYOUT, out, 1, slave ready
- HRESP, out, 1, 1 = ERROR
- addr, out, 32, latched register address
- wdata, out, 32, write data to register blocks
- ren, out, 1, read strobe
- wen, out, 1, write strobe
- addr_valid1, out, 1, window 1 hit
- addr_valid2, out, 1, window 2 hit
- addr_valid3, out, 1, window 3 hit
- rdata, in, 32, muxed read data from the rdata arbiter
REQ-003 One clock (HCLK) SHALL be used; HRESET SHALL be synchronous and active-high.

Function
REQ-004 Address phase accepted only when HSEL & HREADY & HTRANS[1] are all high at a rising edge; HADDR, HWRITE and HSIZE are then latched.
REQ-005 Window n hit SHALL be HADDR[31:WIN_BITS] == BASEn[31:WIN_BITS]; on overlapping windows, priority is 1 > 2 > 3.
REQ-006 An accepted transfer SHALL be an error if it hits no window, HSIZE > 2, or HADDR is misaligned for HSIZE.
REQ-007 FSM states SHALL be IDLE, RD_WAIT, RD_DONE, WR, ERR1, ERR2.
REQ-008 State after an accepted transfer: error -> ERR1; read -> RD_WAIT; write -> WR.
REQ-009 State when no transfer is accepted: RD_WAIT -> RD_DONE; ERR1 -> ERR2; any other state -> IDLE.
REQ-010 In IDLE: HREADYOUT=1, HRESP=0, ren=wen=0, all addr_valid=0.
REQ-011 In RD_WAIT: ren=1, the selected addr_valid=1, HREADYOUT=0, HRESP=0; rdata is registered into HRDATA at the end of the cycle.
REQ-012 In RD_DONE: HREADYOUT=1, HRESP=0, ren=0; read latency is exactly one wait state.
REQ-013 In WR: wen=1, wdata=HWDATA (combinational), selected addr_valid=1, HREADYOUT=1; zero wait states.
REQ-014 In ERR1: HRESP=1, HREADYOUT=0, no strobes. In ERR2: HRESP=1, HREADYOUT=1, no strobes.
REQ-015 A new address phase accepted in IDLE, RD_DONE, WR or ERR2 SHALL proceed back-to-back with no idle cycle.
REQ-016 IDLE/BUSY transfers, HSEL low, or HREADY low SHALL not be accepted and SHALL receive a zero-wait OKAY response.
REQ-017 ren and wen SHALL never be high together; at most one addr_valid SHALL be high; no addr_valid SHALL be high without ren or wen.
REQ-018 HRDATA SHALL hold its last value outside RD_WAIT updates.
REQ-019 addr SHALL hold the latched HADDR until the next accepted transfer.

Reset
REQ-020 While HRESET=1 at a rising edge: state=IDLE, HRDATA=0, addr=0, HREADYOUT=1, HRESP=0, ren=wen=0, all addr_valid=0.
REQ-021 Reset asserted mid-transfer (RD_WAIT, WR, ERR1) SHALL abort it; no strobe is asserted in the cycle after reset.

Verification
REQ-022 Read of 0x8000_1004 with rdata=0xDEAD_BEEF -> one cycle with ren=1, addr_valid2=1, HREADYOUT=0; next cycle HRDATA=0xDEAD_BEEF, HREADYOUT=1.
REQ-023 Write of 0x8000_0010 with HWDATA=0x1234_5678 -> data-phase cycle with wen=1, addr_valid1=1, wdata=0x1234_5678, HREADYOUT=1.
REQ-024 Read of unmapped 0x9000_0000 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1; ren=0 throughout.
REQ-025 Back-to-back write 0x8000_2000 then read 0x8000_0000 -> wen/addr_valid3, then ren/addr_valid1 the next cycle, with no gap.
REQ-026 HRESET asserted during RD_WAIT -> next cycle in IDLE with HRDATA=0 and ren=0.
REQ-027 HSIZE=2 with HADDR=0x8000_0002 -> two-cycle ERROR response and no strobes.
